instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Instruction-fetch stage of the MIPS pipeline and the requesting end of the instruction-memory interface. It owns the program counter and drives the word address into the combinational instruction memory. It latches the returned instruction and PC+4 into the IF/ID pipeline register. It also handles stall, flush, and branch/jump redirection from later stages.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- Clk_in  input  1  pipeline clock, all state updates on rising edge
- Rst  input  1  asynchronous, active-high reset
- Stall  input  1  hold PC and IF/ID contents (hazard unit)
- Flush  input  1  squash the instruction entering IF/ID this edge
- BranchTaken  input  1  redirect to BranchTarget (resolved in EX)
- BranchTarget  input  32  branch destination byte address
- Jump  input  1  redirect to JumpTarget (resolved in ID)
- JumpTarget  input  32  jump destination byte address
- IMemInstruction  input  32  word returned by instruction memory for IMemAddress
- IMemAddress  output  32  current PC, byte address to instruction memory
- IF_ID_Instruction  output  32  latched instruction
- IF_ID_PCPlus4  output  32  latched PC+4 of that instruction
- IF_ID_Valid  output  1  latched slot holds a real instruction
- Misaligned  output  1  sticky: a redirect target had bits [1:0] != 0
- FetchCount  output  32  only with FETCH_COUNT_EN (see Configuration)

## Operation
- The PC register drives IMemAddress directly, with no logic between the register and the port.
- Next-PC priority, highest first:
  - Rst: RESET_PC.
  - BranchTaken: {BranchTarget[31:2],2'b00}.
  - Jump: {JumpTarget[31:2],2'b00}.
  - Stall: hold.
  - Otherwise: PC+4.
- Branch beats Jump because the branch belongs to the older instruction.
- A redirect overrides Stall for the PC.
- PC+4 is a 32-bit add with wrap-around: 32'hFFFF_FFFC → 32'h0000_0000. Overflow is ignored.
- IF/ID update priority, highest first:
  - Rst.
  - Flush: Instruction=32'h0, PCPlus4=0, Valid=0.
  - Stall: hold all three fields.
  - Otherwise: Instruction=IMemInstruction, PCPlus4=PC+4, Valid=1.
- Flush beats Stall.
- The unit never flushes itself on a redirect. The hazard unit asserts Flush alongside BranchTaken or Jump when the wrong-path slot must die.
- Misaligned:
  - Set on any edge where the selected redirect target has bits [1:0] != 2'b00.
  - Only the selected redirect is checked. A non-selected Jump target does not set it.
  - Cleared only by Rst.
  - Low bits are forced to zero regardless.

## Timing
- Reset values, applied immediately on Rst high, independent of the clock:
  - PC = RESET_PC.
  - IF_ID_Instruction = 0.
  - IF_ID_PCPlus4 = 0.
  - IF_ID_Valid = 0.
  - Misaligned = 0.
  - FetchCount = 0.
- First edge after Rst deasserts: IF/ID captures the word at RESET_PC and PC becomes RESET_PC+4.
- Fetch latency: the word at PC appears on IF_ID_Instruction one edge after PC is presented. Instruction memory is combinational, so the word is valid within the same cycle.
- Redirect latency: a target asserted in cycle N is on IMemAddress in cycle N+1. Its instruction is in IF/ID in cycle N+2.
- Steady state, no hazards: one instruction per cycle.
- Stall held k cycles: PC and IF/ID frozen k cycles, no instruction lost or duplicated.
- Rst asserted mid-stream: all in-flight state is discarded and no partial update occurs. Rst beats every other input on the same edge.

## Configuration
- FETCH_COUNT_EN defined:
  - Port FetchCount exists.
  - It is a 32-bit counter, reset to 0.
  - It increments on each edge where IF/ID loads a valid instruction (not Rst, not Flush, not Stall).
  - It wraps 32'hFFFF_FFFF → 0.
- FETCH_COUNT_EN undefined: port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset then free-run with memory[i]=i*3 → IMemAddress 0,4,8,12; IF_ID_Instruction 0,3,6 one cycle behind; IF_ID_PCPlus4 4,8,12; Valid rises first edge.
- Stall held 3 cycles at PC=0x10 → IMemAddress stays 0x10, IF/ID frozen, then resumes 0x14; FetchCount advances by exactly the unstalled cycles.
- BranchTaken=1, BranchTarget=0x40 with Jump=1, JumpTarget=0x80, and Stall=1, all in the same cycle → next IMemAddress=0x40; Misaligned stays 0.
- Jump to 0x22 with Flush=1 → IMemAddress=0x20, Misaligned=1 and sticky, IF_ID_Valid=0 and IF_ID_Instruction=0 that edge.
- Flush and Stall together → IF/ID cleared, not held.
- Rst pulsed asynchronously mid-cycle at PC=0x30 → outputs return to reset values before the next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module   : instruction_fetch_unit_if
// Purpose  : Fetch-stage bundle: hazard/redirect inputs, instruction-memory
//            port and IF/ID register outputs. FetchCount only with FETCH_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IMemInstruction;
  logic [31:0] IMemAddress;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        Misaligned;
`ifdef FETCH_COUNT_EN
  logic [31:0] FetchCount;
`endif

  modport master (
    input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget,
           IMemInstruction,
    output IMemAddress, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
           Misaligned
`ifdef FETCH_COUNT_EN
    , output FetchCount
`endif
  );

  modport slave (
    output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget,
           IMemInstruction,
    input  IMemAddress, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
           Misaligned
`ifdef FETCH_COUNT_EN
    , input FetchCount
`endif
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : MIPS IF stage: PC, next-PC select, IF/ID register, sticky
//            misaligned-target flag. Optional macro FETCH_COUNT_EN adds a
//            valid-fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     Clk_in,
  input  logic                     Rst,
  instruction_fetch_unit_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        target_misaligned;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misaligned;
  logic        load_ifid;

  assign pc_plus4  = pc + 32'd4;
  assign load_ifid = !bus.Flush && !bus.Stall;

  // Branch wins over Jump: it belongs to the older instruction in EX.
  always_comb begin
    redirect          = bus.BranchTaken | bus.Jump;
    redirect_target   = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
    target_misaligned = redirect && (redirect_target[1:0] != 2'b00);
    next_pc           = pc;
    if (redirect)
      next_pc = {redirect_target[31:2], 2'b00};
    else if (!bus.Stall)
      next_pc = pc_plus4;
  end

  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      pc <= next_pc;
      if (target_misaligned)
        misaligned <= 1'b1;
    end
  end

  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      ifid_instruction <= 32'h0;
      ifid_pc_plus4    <= 32'h0;
      ifid_valid       <= 1'b0;
    end else if (bus.Flush) begin
      ifid_instruction <= 32'h0;
      ifid_pc_plus4    <= 32'h0;
      ifid_valid       <= 1'b0;
    end else if (!bus.Stall) begin
      ifid_instruction <= bus.IMemInstruction;
      ifid_pc_plus4    <= pc_plus4;
      ifid_valid       <= 1'b1;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;

  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst)
      fetch_count <= 32'h0;
    else if (load_ifid)
      fetch_count <= fetch_count + 32'd1;
  end

  assign bus.FetchCount = fetch_count;
`else
  logic unused_load_ifid;
  assign unused_load_ifid = load_ifid;
`endif

  assign bus.IMemAddress       = pc;
  assign bus.IF_ID_Instruction = ifid_instruction;
  assign bus.IF_ID_PCPlus4     = ifid_pc_plus4;
  assign bus.IF_ID_Valid       = ifid_valid;
  assign bus.Misaligned        = misaligned;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed self-checking bench; memory word i holds i*3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  logic Clk_in;
  logic Rst;
  int   checks;
  int   errors;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk_in (Clk_in),
    .Rst    (Rst),
    .bus    (bus)
  );

  assign bus.IMemInstruction = (bus.IMemAddress >> 2) * 32'd3;

  initial Clk_in = 1'b0;
  always #5 Clk_in = ~Clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Stall        = 1'b0;
    bus.Flush        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'h0;
    bus.Jump         = 1'b0;
    bus.JumpTarget   = 32'h0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [31:0] pcp4,
                             input logic valid, input logic mis, input logic [31:0] fc);
    check({tag, ".addr"},  bus.IMemAddress, addr);
    check({tag, ".instr"}, bus.IF_ID_Instruction, instr);
    check({tag, ".pcp4"},  bus.IF_ID_PCPlus4, pcp4);
    check({tag, ".valid"}, {31'h0, bus.IF_ID_Valid}, {31'h0, valid});
    check({tag, ".mis"},   {31'h0, bus.Misaligned}, {31'h0, mis});
`ifdef FETCH_COUNT_EN
    check({tag, ".fc"},    bus.FetchCount, fc);
`else
    if (fc == 32'hFFFF_FFFF) $display("note: unreachable count");
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst    = 1'b1;
    clear_inputs();
    #1;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    step();
    Rst = 1'b0;

    // Free run: fetch stream lags the PC by one edge
    step(); check_state("run1", 32'h04, 32'd0, 32'h04, 1'b1, 1'b0, 32'd1);
    step(); check_state("run2", 32'h08, 32'd3, 32'h08, 1'b1, 1'b0, 32'd2);
    step(); check_state("run3", 32'h0C, 32'd6, 32'h0C, 1'b1, 1'b0, 32'd3);
    step(); check_state("run4", 32'h10, 32'd9, 32'h10, 1'b1, 1'b0, 32'd4);

    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_state("stall", 32'h10, 32'd9, 32'h10, 1'b1, 1'b0, 32'd4);
    end
    bus.Stall = 1'b0;
    step(); check_state("resume", 32'h14, 32'd12, 32'h14, 1'b1, 1'b0, 32'd5);

    // Branch beats Jump and overrides Stall for the PC; IF/ID holds
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h40;
    bus.Jump = 1'b1; bus.JumpTarget = 32'h80; bus.Stall = 1'b1;
    step(); check_state("br_prio", 32'h40, 32'd12, 32'h14, 1'b1, 1'b0, 32'd5);
    clear_inputs();
    step(); check_state("br_next", 32'h44, 32'd48, 32'h44, 1'b1, 1'b0, 32'd6);

    bus.Jump = 1'b1; bus.JumpTarget = 32'h22; bus.Flush = 1'b1;
    step(); check_state("jmp_mis", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'd6);
    clear_inputs();
    step(); check_state("mis_sticky", 32'h24, 32'd24, 32'h24, 1'b1, 1'b1, 32'd7);

    // PC+4 wrap-around at the top of the address space
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'hFFFF_FFFC;
    step(); check_state("wrap_br", 32'hFFFF_FFFC, 32'd27, 32'h28, 1'b1, 1'b1, 32'd8);
    clear_inputs();
    step(); check_state("wrap", 32'h0, 32'hBFFF_FFFD, 32'h0, 1'b1, 1'b1, 32'd9);

    bus.Flush = 1'b1; bus.Stall = 1'b1;
    step(); check_state("flush_stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd9);
    clear_inputs();
    step(); check_state("after_fs", 32'h04, 32'd0, 32'h04, 1'b1, 1'b1, 32'd10);

    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h30;
    step(); check_state("to_30", 32'h30, 32'd3, 32'h08, 1'b1, 1'b1, 32'd11);
    clear_inputs();
    #3 Rst = 1'b1;
    #1 check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    step();
    check_state("rst_held", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    Rst = 1'b0;
    step(); check_state("restart", 32'h04, 32'd0, 32'h04, 1'b1, 1'b0, 32'd1);

    // Only the selected redirect target is checked for alignment
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h50;
    bus.Jump = 1'b1; bus.JumpTarget = 32'h23;
    step(); check_state("jmp_unsel", 32'h50, 32'd3, 32'h08, 1'b1, 1'b0, 32'd2);
    clear_inputs();
    step(); check_state("after_unsel", 32'h54, 32'd60, 32'h54, 1'b1, 1'b0, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
